// File: rtl/xbar_pkg.sv
// xbar_pkg: shared types and constants for the xbar switch, including the
// serial frame receiver front end (des_frame_rx).
//
// Contents:
//   ports, packet_width : default channel count and payload width
//   FRAME_W             : serial frame length (start + payload + parity)
//   des_state_t         : per-channel receive FSM states
//   par_ok()            : parity check helper
package xbar_pkg;

  localparam int ports        = 4;
  localparam int packet_width = 8;
  localparam int FRAME_W      = packet_width + 2;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PAR
  } des_state_t;

  // The data argument is 64 bits wide so any payload width up to 64 can be
  // passed zero-extended; the zero padding does not change the XOR.
  // Returns 1 when the XOR of data and parity bit matches the selected sense
  // (0 for even parity, 1 for odd parity).
  function automatic logic par_ok(input logic [63:0] data,
                                  input logic        par_bit,
                                  input logic        odd);
    return ((^data) ^ par_bit) == odd;
  endfunction

endpackage

// File: rtl/des_frame_rx_lane.sv
// des_frame_lane: one receive channel of des_frame_rx.
//
// Detects a start bit, shifts in DATA_W payload bits MSB first, checks the
// trailing parity bit and pushes good words into a FIFO_DEPTH-entry FIFO
// with a valid/ready output. Sticky parity and overflow flags are cleared
// by err_clr; a new error in the same cycle as err_clr wins.
//
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   serial_in     serial bit, sampled every clk (idle level 0)
//   out_data      head-of-FIFO word (0 when empty)
//   out_valid     FIFO non-empty
//   out_ready     consumer accepts; pop on out_valid && out_ready
//   parity_err    sticky parity-error flag
//   ovf_err       sticky overflow flag
//   err_clr       clears both sticky flags on the next edge
//   frame_cnt     good frames pushed, saturating (DES_FRAME_STATS_EN only)
//   err_cnt       parity/overflow drops, saturating (DES_FRAME_STATS_EN only)
//
// Optional feature macro: DES_FRAME_STATS_EN.
module des_frame_lane
  import xbar_pkg::*;
#(
  parameter int DATA_W     = packet_width,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              parity_err,
  output logic              ovf_err,
`ifdef DES_FRAME_STATS_EN
  output logic [15:0]       frame_cnt,
  output logic [15:0]       err_cnt,
`endif
  input  logic              err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  des_state_t        state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              parity_err_q, parity_err_d;
  logic              ovf_err_q, ovf_err_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];

  logic frame_done;
  logic par_good;
  logic push_req, push_ok, par_bad, ovf_drop;
  logic empty, full, pop;

  // Receive FSM: start bit in IDLE, DATA_W shifts in SHIFT, parity in PAR.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (serial_in) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        shift_d   = {shift_q[DATA_W-2:0], serial_in};
        bit_cnt_d = bit_cnt_q + CW'(1);
        if (bit_cnt_q == LAST_BIT) state_d = PAR;
      end
      PAR: begin
        // Unconditional return to IDLE lets a start bit follow immediately.
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign par_good = par_ok(64'(shift_q), serial_in, PARITY_ODD != 0);
  assign push_req = frame_done && par_good;
  assign par_bad  = frame_done && !par_good;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index with differing wrap bit means full.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop      = !empty && out_ready;
  // A pop on the same edge frees the slot the push needs.
  assign push_ok  = push_req && (!full || pop);
  assign ovf_drop = push_req && full && !pop;

  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q[AW-1:0]] = shift_q;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  // New errors take priority over a same-cycle clear.
  always_comb begin
    parity_err_d = parity_err_q;
    ovf_err_d    = ovf_err_q;
    if (err_clr) begin
      parity_err_d = 1'b0;
      ovf_err_d    = 1'b0;
    end
    if (par_bad)  parity_err_d = 1'b1;
    if (ovf_drop) ovf_err_d    = 1'b1;
  end

  // NOTE: sequential state is updated with non-blocking assignments so all
  // registers see the pre-edge values of each other.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      parity_err_q <= 1'b0;
      ovf_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      parity_err_q <= parity_err_d;
      ovf_err_q    <= ovf_err_d;
    end
  end

  // NOTE: the FIFO storage has no reset; entries are only visible through
  // the pointers, and out_data is forced to 0 while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_valid  = !empty;
  assign out_data   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign parity_err = parity_err_q;
  assign ovf_err    = ovf_err_q;

`ifdef DES_FRAME_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // A frame is either pushed, dropped for parity or dropped for overflow,
  // so each frame contributes at most one count.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (push_ok && (frame_cnt_q != 16'hFFFF))
      frame_cnt_d = frame_cnt_q + 16'd1;
    if ((par_bad || ovf_drop) && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: rtl/des_frame_rx.sv
// des_frame_rx: multi-channel serial frame receiver for the xbar ingress.
//
// NUM_CH independent channels, each an instance of des_frame_lane. Per-channel
// vectors are flattened: channel i occupies out_data[i*DATA_W +: DATA_W] and
// frame_cnt/err_cnt[i*16 +: 16].
//
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   serial_in     one serial bit per channel (idle level 0)
//   out_data      head-of-FIFO word per channel (0 when empty)
//   out_valid     per-channel FIFO non-empty
//   out_ready     per-channel consumer accept
//   parity_err    per-channel sticky parity-error flag
//   ovf_err       per-channel sticky overflow flag
//   err_clr       per-channel sticky flag clear
//   frame_cnt     per-channel good-frame counters (DES_FRAME_STATS_EN only)
//   err_cnt       per-channel error counters (DES_FRAME_STATS_EN only)
//
// Optional feature macro: DES_FRAME_STATS_EN.
module des_frame_rx
  import xbar_pkg::*;
#(
  parameter int NUM_CH     = ports,
  parameter int DATA_W     = packet_width,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        serial_in,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH-1:0]        parity_err,
  output logic [NUM_CH-1:0]        ovf_err,
`ifdef DES_FRAME_STATS_EN
  output logic [NUM_CH*16-1:0]     frame_cnt,
  output logic [NUM_CH*16-1:0]     err_cnt,
`endif
  input  logic [NUM_CH-1:0]        err_clr
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    des_frame_lane #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .PARITY_ODD (PARITY_ODD)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .serial_in  (serial_in[i]),
      .out_data   (out_data[i*DATA_W +: DATA_W]),
      .out_valid  (out_valid[i]),
      .out_ready  (out_ready[i]),
      .parity_err (parity_err[i]),
      .ovf_err    (ovf_err[i]),
`ifdef DES_FRAME_STATS_EN
      .frame_cnt  (frame_cnt[i*16 +: 16]),
      .err_cnt    (err_cnt[i*16 +: 16]),
`endif
      .err_clr    (err_clr[i])
    );
  end

endmodule

// File: tb/tb_des_frame_rx.sv
// Testbench for des_frame_rx: 4 channels, 8-bit payload, 4-deep FIFO,
// even parity. Popped words are compared against a per-channel queue of
// expected words filled when frames are driven.
module tb_des_frame_rx;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;

  logic                     clk;
  logic                     rst;
  logic [NUM_CH-1:0]        serial_in;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;
  logic [NUM_CH-1:0]        parity_err;
  logic [NUM_CH-1:0]        ovf_err;
  logic [NUM_CH-1:0]        err_clr;
`ifdef DES_FRAME_STATS_EN
  logic [NUM_CH*16-1:0]     frame_cnt;
  logic [NUM_CH*16-1:0]     err_cnt;
`endif

  des_frame_rx #(
    .NUM_CH     (NUM_CH),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (4),
    .PARITY_ODD (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .parity_err (parity_err),
    .ovf_err    (ovf_err),
`ifdef DES_FRAME_STATS_EN
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt),
`endif
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q [NUM_CH][$];

  typedef struct {
    int         ch;
    logic [7:0] data;
    logic       bad;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_perr;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] data_of(input int ch);
    return out_data[ch*DATA_W +: DATA_W];
  endfunction

  // Scoreboard monitor: just after each falling edge the inputs for the next
  // rising edge are settled, so a valid&&ready here is a pop at that edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (rst && out_valid[c] && out_ready[c]) begin
          if (exp_q[c].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL pop ch%0d: got word %0h, expected no word", c,
                     data_of(c));
          end else begin
            check($sformatf("pop ch%0d data", c), 32'(data_of(c)),
                  32'(exp_q[c].pop_front()));
          end
        end
      end
    end
  end

  // Drive one frame on every channel in en, simultaneously. bad flips the
  // parity bit; exp_push records the word as expected output. rdy_at_par and
  // clr_at_par raise out_ready/err_clr during the parity-bit cycle only.
  task automatic drive_frames(input logic [3:0]      en,
                              input logic [3:0][7:0] d,
                              input logic [3:0]      bad,
                              input logic [3:0]      exp_push,
                              input logic [3:0]      rdy_at_par,
                              input logic [3:0]      clr_at_par);
    logic [9:0] fr [NUM_CH];
    for (int c = 0; c < NUM_CH; c++)
      fr[c] = {1'b1, d[c], (^d[c]) ^ bad[c]};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++)
        serial_in[c] = en[c] ? fr[c][9-k] : 1'b0;
      if (k == 9) begin
        out_ready = out_ready | rdy_at_par;
        err_clr   = err_clr | clr_at_par;
        for (int c = 0; c < NUM_CH; c++)
          if (en[c] && exp_push[c]) exp_q[c].push_back(d[c]);
      end else begin
        out_ready = out_ready & ~rdy_at_par;
        err_clr   = err_clr & ~clr_at_par;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      serial_in = '0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][7:0] d;
    logic [7:0]      part;

    vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{1, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{2, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{3, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{3, 8'h80, 1'b0, 1'b1, 8'h80, 1'b0};
    vecs[5] = '{1, 8'h7E, 1'b0, 1'b1, 8'h7E, 1'b0};

    rst       = 1'b0;
    serial_in = '0;
    out_ready = '0;
    err_clr   = '0;
    @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset out_data", out_data, 32'h0);
    check("reset parity_err", 32'(parity_err), 32'h0);
    check("reset ovf_err", 32'(ovf_err), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    idle_cycles(2);

    // Single-frame vectors (tests 1 and 2).
    for (int i = 0; i < 6; i++) begin
      int c;
      c = vecs[i].ch;
      d = '0;
      d[c] = vecs[i].data;
      drive_frames(4'(1 << c), d, 4'(vecs[i].bad) << c,
                   4'(!vecs[i].bad) << c, 4'h0, 4'h0);
      check($sformatf("vec%0d valid before parity edge", i),
            32'(out_valid[c]), 32'h0);
      idle_cycles(1);
      check($sformatf("vec%0d out_valid", i), 32'(out_valid[c]),
            32'(vecs[i].exp_valid));
      check($sformatf("vec%0d out_data", i), 32'(data_of(c)),
            32'(vecs[i].exp_data));
      check($sformatf("vec%0d parity_err", i), 32'(parity_err[c]),
            32'(vecs[i].exp_perr));
      if (vecs[i].exp_valid) begin
        out_ready[c] = 1'b1;
        @(negedge clk);
        out_ready[c] = 1'b0;
        check($sformatf("vec%0d valid after pop", i), 32'(out_valid[c]), 32'h0);
        check($sformatf("vec%0d data after pop", i), 32'(data_of(c)), 32'h0);
      end
      if (vecs[i].exp_perr) begin
        err_clr[c] = 1'b1;
        @(negedge clk);
        err_clr[c] = 1'b0;
        check($sformatf("vec%0d parity_err cleared", i),
              32'(parity_err[c]), 32'h0);
      end
    end

    // err_clr coinciding with a new bad frame: the error wins.
    d = '0;
    d[1] = 8'h3C;
    drive_frames(4'b0010, d, 4'b0010, 4'b0000, 4'h0, 4'h0);
    idle_cycles(1);
    check("ch1 parity_err set", 32'(parity_err[1]), 32'h1);
    d[1] = 8'h0F;
    drive_frames(4'b0010, d, 4'b0010, 4'b0000, 4'h0, 4'b0010);
    @(negedge clk);
    serial_in = '0;
    err_clr   = '0;
    check("ch1 err wins over clr", 32'(parity_err[1]), 32'h1);
    err_clr[1] = 1'b1;
    @(negedge clk);
    err_clr[1] = 1'b0;
    check("ch1 parity_err clr", 32'(parity_err[1]), 32'h0);

    // Overflow on ch2: five back-to-back frames, no ready.
    for (int i = 1; i <= 5; i++) begin
      d = '0;
      d[2] = 8'(i);
      drive_frames(4'b0100, d, 4'h0, (i <= 4) ? 4'b0100 : 4'b0000, 4'h0, 4'h0);
    end
    idle_cycles(1);
    check("ch2 ovf_err", 32'(ovf_err[2]), 32'h1);
    check("ch2 head word", 32'(data_of(2)), 32'h01);
    check("ch2 parity_err clean", 32'(parity_err[2]), 32'h0);
    check("ch2 no ovf on others", 32'(ovf_err & 4'b1011), 32'h0);
    out_ready[2] = 1'b1;
    idle_cycles(4);
    out_ready[2] = 1'b0;
    check("ch2 drained", 32'(out_valid[2]), 32'h0);
    err_clr[2] = 1'b1;
    @(negedge clk);
    err_clr[2] = 1'b0;
    check("ch2 ovf_err clr", 32'(ovf_err[2]), 32'h0);

    // All channels concurrently, random ready.
    d = {8'h44, 8'h33, 8'h22, 8'h11};
    drive_frames(4'hF, d, 4'h0, 4'hF, 4'h0, 4'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      serial_in = '0;
      out_ready = 4'($urandom);
    end
    out_ready = 4'hF;
    idle_cycles(2);
    out_ready = '0;
    check("concurrent drained", 32'(out_valid), 32'h0);
    check("concurrent no errors", 32'({parity_err, ovf_err}), 32'h0);

    // Reset mid-frame, with a word buffered on ch0 and a flag set on ch1.
    d = {8'h00, 8'h00, 8'h77, 8'h99};
    drive_frames(4'b0011, d, 4'b0010, 4'b0001, 4'h0, 4'h0);
    idle_cycles(1);
    check("pre-reset ch0 valid", 32'(out_valid[0]), 32'h1);
    check("pre-reset ch1 perr", 32'(parity_err[1]), 32'h1);
    part = 8'hC3;
    @(negedge clk);
    serial_in[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      serial_in[3] = part[7-k];
    end
    @(negedge clk);
    rst       = 1'b0;
    serial_in = '0;
    for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
    #1;
    check("midreset out_valid", 32'(out_valid), 32'h0);
    check("midreset out_data", out_data, 32'h0);
    check("midreset flags", 32'({parity_err, ovf_err}), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    d = '0;
    d[3] = 8'h5A;
    drive_frames(4'b1000, d, 4'h0, 4'b1000, 4'h0, 4'h0);
    idle_cycles(1);
    check("post-reset ch3 data", 32'(data_of(3)), 32'h5A);
    check("post-reset valid", 32'(out_valid), 32'b1000);
    check("post-reset flags", 32'({parity_err, ovf_err}), 32'h0);
    out_ready[3] = 1'b1;
    @(negedge clk);
    out_ready[3] = 1'b0;

    // Full FIFO with a pop on the push edge, then continued wrap-around.
    for (int i = 0; i < 4; i++) begin
      d = '0;
      d[0] = 8'h60 + 8'(i);
      drive_frames(4'b0001, d, 4'h0, 4'b0001, 4'h0, 4'h0);
    end
    d = '0;
    d[0] = 8'h64;
    drive_frames(4'b0001, d, 4'h0, 4'b0001, 4'b0001, 4'h0);
    @(negedge clk);
    serial_in = '0;
    out_ready = '0;
    check("full push+pop ovf_err", 32'(ovf_err[0]), 32'h0);
    check("full push+pop head", 32'(data_of(0)), 32'h61);
    for (int i = 0; i < 10; i++) begin
      d = '0;
      d[0] = 8'h70 + 8'(i);
      drive_frames(4'b0001, d, 4'h0, 4'b0001, 4'b0001, 4'h0);
    end
    @(negedge clk);
    serial_in = '0;
    out_ready = '0;
    check("wrap ovf_err", 32'(ovf_err[0]), 32'h0);
    check("wrap head", 32'(data_of(0)), 32'h76);
    out_ready = 4'hF;
    idle_cycles(5);
    out_ready = '0;
    check("wrap drained", 32'(out_valid[0]), 32'h0);

    for (int c = 0; c < NUM_CH; c++)
      check($sformatf("ch%0d words never delivered", c),
            32'(exp_q[c].size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/des_frame_rx.md
Name: des_frame_rx

Overview:
- Parametrised multi-channel serial frame receiver; successor to the fixed-width per-port deserializer front end of the xbar switch.
- Each channel detects a start bit, shifts in DATA_W payload bits MSB-first, checks a parity bit and buffers good words in a per-channel FIFO.
- Each channel's FIFO has a valid/ready output handshake.
- Sits between the serial input pins and the xbar ingress logic; adds framing, error detection and backpressure.

Parameters:
- NUM_CH, default xbar_pkg::ports: number of independent serial channels.
- DATA_W, default xbar_pkg::packet_width: payload bits per frame. Frame length is DATA_W+2.
- FIFO_DEPTH, default 4: words buffered per channel. Power of 2, ≥2.
- PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-low reset
- serial_in  in  NUM_CH  one serial bit per channel, sampled every clk; idle level 0
- out_data  out  [DATA_W-1:0] x NUM_CH  head-of-FIFO word per channel
- out_valid  out  NUM_CH  FIFO non-empty, per channel
- out_ready  in  NUM_CH  consumer accepts; pop when valid&&ready
- parity_err  out  NUM_CH  sticky parity-error flag
- ovf_err  out  NUM_CH  sticky overflow flag
- err_clr  in  NUM_CH  clears that channel's sticky flags

Behaviour:
- Frame format: start bit '1', then DATA_W data bits MSB first, then 1 parity bit.
  - Even parity: XOR of data and parity bit is 0.
  - Odd parity: XOR of data and parity bit is 1.
- Reset (rst=0, async): FSM→IDLE, bit counter 0, FIFO empty.
  - out_valid=0, out_data=0, parity_err=0, ovf_err=0.
- Per-channel FSM, states IDLE, SHIFT, PAR:
  - IDLE: serial_in=1 on an edge → SHIFT with bit_cnt=0; else stay in IDLE.
  - SHIFT: each edge shifts serial_in into shift_reg LSB and increments bit_cnt. At bit_cnt=DATA_W-1 → PAR.
  - PAR: the edge samples the parity bit, then → IDLE unconditionally.
    - Parity good: word pushed on this same edge.
    - Parity bad: word dropped, parity_err set.
- Latency: start bit sampled at edge 0, data at edges 1..DATA_W, parity at edge DATA_W+1. out_valid is high after edge DATA_W+1 if the FIFO was empty.
- Back-to-back frames: a start bit in the cycle right after the parity bit is accepted. There is no minimum idle gap.
- FIFO:
  - out_data shows the head entry; it is 0 when empty.
  - Pop on valid&&ready; ordering is strictly FIFO.
  - Push when full without a same-cycle pop: word dropped, contents unchanged, ovf_err set.
  - Push and pop in the same cycle when full: both happen, no overflow.
  - Push and pop in the same cycle when empty: push takes effect, out_valid=1 next cycle.
  - Pointers are log2(FIFO_DEPTH)+1 bits; full/empty is decided by MSB compare. Wrap-around must be lossless.
- Sticky flags: err_clr clears the flag on the next edge. If err_clr and a new error occur in the same cycle, the error wins and the flag stays 1.
- Channels are fully independent; no shared state.
- Reset mid-frame: the partial frame is discarded and buffered words are lost. After release, serial_in=1 is treated as a start bit.

Optional Feature:
- Macro DES_FRAME_STATS_EN.
- Defined: adds per-channel outputs frame_cnt[15:0] and err_cnt[15:0], both reset to 0 and saturating at 0xFFFF.
  - frame_cnt increments on every good frame pushed.
  - err_cnt increments on every parity error or overflow drop; a single frame counts as one error.
  - err_clr does not clear the counters.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Additions to xbar_pkg:
  - typedef enum des_state_t {IDLE, SHIFT, PAR}
  - localparam FRAME_W = packet_width+2
  - parity helper function par_ok(data, bit, odd)
- Sub-module des_frame_lane: one channel's FSM, FIFO and flags. The top generates NUM_CH instances of it.

Test Plan (NUM_CH=4, DATA_W=8, FIFO_DEPTH=4, even parity):
1. ch0 sends start, 0xA5, parity 0 → out_valid[0]=1 after edge 9; out_data[0]=0xA5; pop with ready → out_valid[0]=0, out_data[0]=0.
2. ch1 sends 0x3C with parity 1 → no push, parity_err[1]=1; pulse err_clr[1] → flag 0. err_clr in the same cycle as a new bad frame → flag stays 1.
3. ch2 sends 0x01..0x05 back-to-back with out_ready=0 → 0x01..0x04 buffered, ovf_err[2]=1, 0x05 dropped. Drain → 0x01,0x02,0x03,0x04 in order.
4. All four channels send 0x11/0x22/0x33/0x44 concurrently with random out_ready → each channel delivers only its own byte; no cross-talk.
5. rst low after 4 data bits of ch3 → all outputs 0. After release, frame 0x5A → out_data[3]=0x5A, no errors.
6. FIFO full with out_ready=1 while a new frame's parity edge arrives → pop and push both happen; ovf_err stays 0. 10 more frames then check pointer wrap.
